// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop input synchroniser, mid-bit sampling,
// false-start rejection, optional parity, 1 or 2 stop bits, and break
// detection. One recv_en pulse per completed frame; data and flags hold
// until the next pulse. DATA_BITS must lie in 5..9.
module uart_rx_param #(
  parameter int CLK_FRE   = 50,       // system clock in MHz
  parameter int UART_RATE = 115200,   // baud rate in bit/s
  parameter int DATA_BITS = 8,        // 5..9
  parameter int PARITY    = 0,        // 0 none, 1 odd, 2 even
  parameter int STOP_BITS = 1         // 1 or 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  output logic                 recv_en,
  output logic [DATA_BITS-1:0] recv_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int RATE_CNT = CLK_FRE * 1000000 / UART_RATE - 1;
  localparam int CNT_W    = (RATE_CNT > 0) ? $clog2(RATE_CNT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(RATE_CNT);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(RATE_CNT / 2);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 recv_en_q, recv_en_d;
  logic [DATA_BITS-1:0] recv_data_q, recv_data_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_det_q, break_det_d;

  logic rx_s;
  logic exp_par;
  logic ferr_now;
  logic brk_now;

  assign rx_s = sync_q[1];

  // Even parity expects the XOR of the data bits; odd parity its inverse.
  assign exp_par = (^shift_q) ^ (PARITY == 1);

  // State register and all datapath flops, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      recv_en_q    <= 1'b0;
      recv_data_q  <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      recv_en_q    <= recv_en_d;
      recv_data_q  <= recv_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
    end
  end

  // Next-state and datapath logic; outputs are registered so recv_en lands
  // on the cycle after the final stop-bit sample.
  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[0], rx_pin};
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    recv_en_d    = 1'b0;
    recv_data_d  = recv_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;
    ferr_now     = ferr_q | ~rx_s;
    brk_now      = ferr_now && (shift_q == '0) && !par_bit_q;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      // Re-check the line half a bit in; a high level was only a glitch.
      S_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            bit_cnt_d = '0;
            par_bit_d = 1'b0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
            state_d   = S_DATA;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      // Shift right so the first bit on the wire ends up in the LSB.
      S_DATA: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          par_bit_d = rx_s;
          perr_d    = (rx_s != exp_par);
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      // Leave right at the last stop-bit sample so a back-to-back start
      // edge half a bit later is still caught.
      S_STOP: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          ferr_d    = ferr_now;
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d    = '0;
            recv_en_d    = 1'b1;
            recv_data_d  = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_now;
            break_det_d  = brk_now;
            state_d      = brk_now ? S_BREAK : S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      // Stay here while the line is held low so a break yields one pulse.
      S_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign recv_en    = recv_en_q;
  assign recv_data  = recv_data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four receivers with different frame formats share
// one clock and reset. Stimulus pushes expected frames into a scoreboard
// queue; a monitor on the falling edge pops and compares on each recv_en.
module tb_uart_rx_param;

  localparam int CLK_FRE   = 50;
  localparam int UART_RATE = 5_000_000;
  localparam int BIT       = CLK_FRE * 1_000_000 / UART_RATE;  // clocks per bit
  localparam int NI        = 4;

  localparam int DB_T   [NI] = '{8, 8, 8, 5};
  localparam int PAR_T  [NI] = '{0, 2, 0, 1};
  localparam int STOP_T [NI] = '{1, 1, 2, 2};

  typedef struct {
    int          idx;
    logic [8:0]  data;
    bit          perr;
    bit          ferr;
    bit          brk;
    longint      t0;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] rx_line = '1;
  logic [NI-1:0] recv_en;
  logic [NI-1:0] parity_err;
  logic [NI-1:0] frame_err;
  logic [NI-1:0] break_det;
  logic [8:0]    recv_data [NI];

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      logic [DB_T[gi]-1:0] rd_w;
      uart_rx_param #(
        .CLK_FRE  (CLK_FRE),
        .UART_RATE(UART_RATE),
        .DATA_BITS(DB_T[gi]),
        .PARITY   (PAR_T[gi]),
        .STOP_BITS(STOP_T[gi])
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rx_pin    (rx_line[gi]),
        .recv_en   (recv_en[gi]),
        .recv_data (rd_w),
        .parity_err(parity_err[gi]),
        .frame_err (frame_err[gi]),
        .break_det (break_det[gi])
      );
      assign recv_data[gi] = 9'(rd_w);
    end
  endgenerate

  task automatic check(input string name, input int i, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, i, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected clocks from the start-bit falling edge to the recv_en pulse.
  function automatic int exp_latency(input int i);
    int rc = BIT - 1;
    int p  = (PAR_T[i] != 0) ? 1 : 0;
    return 2 + (rc / 2 + 1) + (DB_T[i] + p + STOP_T[i]) * BIT + 1;
  endfunction

  // Drives one frame on line i and records what the receiver must report.
  task automatic send_frame(input int i, input logic [8:0] d, input bit flip_par,
                            input bit [1:0] stop_low, input int gap);
    exp_t       e;
    logic [8:0] dm;
    bit         pbit;
    int         ones;
    dm   = d & (9'h1FF >> (9 - DB_T[i]));
    pbit = ^dm;
    if (PAR_T[i] == 1) pbit = ~pbit;
    if (flip_par) pbit = ~pbit;
    ones   = $countones(dm) + int'(pbit);
    e.idx  = i;
    e.data = dm;
    e.perr = (PAR_T[i] == 2) ? (ones % 2 != 0) :
             (PAR_T[i] == 1) ? (ones % 2 != 1) : 1'b0;
    e.ferr = stop_low[0] || (STOP_T[i] == 2 && stop_low[1]);
    e.brk  = e.ferr && (dm == 0) && (PAR_T[i] == 0 || pbit == 1'b0);
    e.t0   = cyc;
    exp_q.push_back(e);
    $display("send dut%0d data=0x%03h par_flip=%0b stop_low=%02b gap=%0d", i, dm, flip_par, stop_low, gap);
    rx_line[i] = 1'b0;
    tick(BIT);
    for (int b = 0; b < DB_T[i]; b++) begin
      rx_line[i] = dm[b];
      tick(BIT);
    end
    if (PAR_T[i] != 0) begin
      rx_line[i] = pbit;
      tick(BIT);
    end
    for (int s = 0; s < STOP_T[i]; s++) begin
      rx_line[i] = ~stop_low[s];
      tick(BIT);
    end
    rx_line[i] = 1'b1;
    if (gap > 0) tick(gap);
  endtask

  // Scoreboard monitor: compares each pulse and checks outputs hold between pulses.
  logic [8:0]    last_data [NI];
  logic [NI-1:0] last_pe, last_fe, last_bd, prev_en;
  exp_t          mon_e;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        last_data[i] = '0;
        last_pe[i]   = 1'b0;
        last_fe[i]   = 1'b0;
        last_bd[i]   = 1'b0;
        prev_en[i]   = 1'b0;
      end else if (recv_en[i]) begin
        check("pulse_width", i, longint'(prev_en[i]), 0);
        if (exp_q.size() == 0 || exp_q[0].idx != i) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse dut%0d: got recv_en=1 data=0x%03h, expected no pulse", i, recv_data[i]);
        end else begin
          mon_e = exp_q.pop_front();
          check("recv_data", i, longint'(recv_data[i]), longint'(mon_e.data));
          check("parity_err", i, longint'(parity_err[i]), longint'(mon_e.perr));
          check("frame_err", i, longint'(frame_err[i]), longint'(mon_e.ferr));
          check("break_det", i, longint'(break_det[i]), longint'(mon_e.brk));
          checks++;
          if (cyc - mon_e.t0 < exp_latency(i) - 1 || cyc - mon_e.t0 > exp_latency(i) + 1) begin
            errors++;
            $display("FAIL latency dut%0d: got %0d, expected %0d +/-1", i, cyc - mon_e.t0, exp_latency(i));
          end
          $display("recv dut%0d data=0x%03h perr=%0b ferr=%0b brk=%0b lat=%0d", i, recv_data[i],
                   parity_err[i], frame_err[i], break_det[i], cyc - mon_e.t0);
        end
        last_data[i] = recv_data[i];
        last_pe[i]   = parity_err[i];
        last_fe[i]   = frame_err[i];
        last_bd[i]   = break_det[i];
        prev_en[i]   = 1'b1;
      end else begin
        prev_en[i] = 1'b0;
        check("hold_data", i, longint'(recv_data[i]), longint'(last_data[i]));
        check("hold_flags", i, longint'({parity_err[i], frame_err[i], break_det[i]}),
              longint'({last_pe[i], last_fe[i], last_bd[i]}));
      end
    end
  end

  task automatic check_reset_outputs();
    for (int i = 0; i < NI; i++) begin
      check("rst_recv_en", i, longint'(recv_en[i]), 0);
      check("rst_recv_data", i, longint'(recv_data[i]), 0);
      check("rst_flags", i, longint'({parity_err[i], frame_err[i], break_det[i]}), 0);
    end
  endtask

  initial begin
    int         budget;
    int         i;
    logic [8:0] d;
    bit         flip;
    bit [1:0]   sl;
    bit         ferr_case;

    rst = 1'b1;
    rx_line = '1;
    tick(5);
    check_reset_outputs();
    rst = 1'b0;
    tick(5);

    // 8N1 nominal frame
    send_frame(0, 9'h0A5, 1'b0, 2'b00, 2 * BIT);
    // Even parity: correct then corrupted parity bit
    send_frame(1, 9'h03C, 1'b0, 2'b00, BIT);
    send_frame(1, 9'h03C, 1'b1, 2'b00, 2 * BIT);
    // Stop bit driven low: framing error, not a break
    send_frame(0, 9'h055, 1'b0, 2'b01, 3 * BIT);
    // Short glitch must be rejected, then a normal frame
    rx_line[0] = 1'b0;
    tick(3);
    rx_line[0] = 1'b1;
    tick(2 * BIT);
    send_frame(0, 9'h00F, 1'b0, 2'b00, 2 * BIT);
    // Break: line low for 20 bit periods gives one pulse, then recovery
    begin
      exp_t e;
      e.idx = 0; e.data = '0; e.perr = 1'b0; e.ferr = 1'b1; e.brk = 1'b1; e.t0 = cyc;
      exp_q.push_back(e);
      $display("send dut0 break 20 bit periods");
    end
    rx_line[0] = 1'b0;
    tick(20 * BIT);
    rx_line[0] = 1'b1;
    tick(2 * BIT);
    send_frame(0, 9'h081, 1'b0, 2'b00, 2 * BIT);
    // Two stop bits, back-to-back frames
    send_frame(2, 9'h012, 1'b0, 2'b00, 0);
    send_frame(2, 9'h034, 1'b0, 2'b00, 0);
    // Third frame abandoned by reset mid-data
    $display("send dut2 partial frame, reset mid-frame");
    rx_line[2] = 1'b0;
    tick(BIT);
    for (int b = 0; b < 4; b++) begin
      rx_line[2] = b[0];
      tick(BIT);
    end
    rst = 1'b1;
    tick(1);
    check_reset_outputs();
    rx_line[2] = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2 * BIT);
    send_frame(2, 9'h07E, 1'b0, 2'b00, 2 * BIT);

    // Randomised frames across all receivers
    for (int n = 0; n < 40; n++) begin
      i    = int'($urandom_range(0, NI - 1));
      d    = 9'($urandom);
      if ($urandom_range(0, 6) == 0) d = '0;
      flip = (PAR_T[i] != 0) && ($urandom_range(0, 3) == 0);
      sl   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ferr_case = sl[0] || (STOP_T[i] == 2 && sl[1]);
      send_frame(i, d, flip, sl, ferr_case ? 3 * BIT : int'($urandom_range(0, 15)));
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      tick(1);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d frames outstanding, expected 0", exp_q.size());
    end
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
